// File: rtl/mem_ctrl.sv
// Cache-side 32-bit word requests serialized into byte accesses on a 1-cycle-latency RAM port.
// Optional MEMCTRL_BYTE_SKIP_EN: writes visit only the byte slots enabled in cache_sel_i.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_ce_i,
  input  logic                  cache_we_i,
  input  logic [31:0]           cache_addr_i,
  input  logic [3:0]            cache_sel_i,
  input  logic [31:0]           cache_data_i,
  output logic [31:0]           cache_data_o,
  output logic                  cache_ready_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {IDLE, XFER, RDWAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] base_q, base_d;
  logic                  we_q, we_d;
  logic [31:0]           data_q, data_d;
  logic [23:0]           cap_q, cap_d;
  logic [31:0]           rdata_q, rdata_d;

`ifdef MEMCTRL_BYTE_SKIP_EN
  logic [3:0] sel_q, sel_d;
  logic [2:0] nxt;
  logic       unused_addr;
  assign unused_addr = ^{cache_addr_i[31:ADDR_WIDTH], cache_addr_i[1:0]};

  // {found, slot}: lowest enabled slot at or above 'from'
  function automatic logic [2:0] first_from(input logic [3:0] sel, input int from);
    first_from = 3'b000;
    for (int k = 3; k >= 0; k--)
      if (k >= from && sel[k]) first_from = {1'b1, 2'(k)};
  endfunction
`else
  logic unused_in;
  assign unused_in = ^{cache_addr_i[31:ADDR_WIDTH], cache_addr_i[1:0], cache_sel_i};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    we_d    = we_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
`ifdef MEMCTRL_BYTE_SKIP_EN
    sel_d   = sel_q;
    nxt     = 3'b000;
`endif
    case (state_q)
      IDLE: if (cache_ce_i) begin
        base_d  = cache_addr_i[ADDR_WIDTH-1:2];
        we_d    = cache_we_i;
        data_d  = cache_data_i;
        cnt_d   = 2'd0;
        state_d = XFER;
`ifdef MEMCTRL_BYTE_SKIP_EN
        sel_d = cache_sel_i;
        if (cache_we_i) begin
          nxt   = first_from(cache_sel_i, 0);
          cnt_d = nxt[1:0];
          if (!nxt[2]) state_d = DONE;
        end
`endif
      end
      XFER: begin
        // Byte for address cnt-1 arrives now; shift it in so lane 0 ends at the bottom
        if (!we_q && cnt_q != 2'd0) cap_d = {ram_din_i, cap_q[23:8]};
`ifdef MEMCTRL_BYTE_SKIP_EN
        if (we_q) begin
          nxt = first_from(sel_q, int'(cnt_q) + 1);
          if (nxt[2]) cnt_d = nxt[1:0];
          else        state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = RDWAIT;
        end
`else
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = we_q ? DONE : RDWAIT;
`endif
      end
      RDWAIT: begin
        rdata_d = {ram_din_i, cap_q};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
`ifdef MEMCTRL_BYTE_SKIP_EN
      sel_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
`ifdef MEMCTRL_BYTE_SKIP_EN
      sel_q   <= sel_d;
`endif
    end
  end

  // Slot index replaces the low two bits, so the address never leaves the aligned word
  assign ram_a_o       = (state_q == XFER) ? {base_q, cnt_q} : '0;
  assign ram_wr_o      = (state_q == XFER) && we_q;
  assign ram_dout_o    = ram_wr_o ? 8'(data_q >> {cnt_q, 3'b000}) : 8'h00;
  assign cache_ready_o = (state_q == DONE);
  assign cache_data_o  = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-RAM model, table vectors, corner sequences, random traffic.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ce_i, cache_we_i;
  logic [31:0] cache_addr_i, cache_data_i;
  logic [3:0]  cache_sel_i;
  logic [31:0] cache_data_o;
  logic        cache_ready_o;
  logic [16:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem     [0:131071];  // RAM driven by the DUT
  logic [7:0] ref_mem [0:131071];  // model's view of RAM

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .cache_ce_i(cache_ce_i), .cache_we_i(cache_we_i), .cache_addr_i(cache_addr_i),
    .cache_sel_i(cache_sel_i), .cache_data_i(cache_data_i),
    .cache_data_o(cache_data_o), .cache_ready_o(cache_ready_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_o) mem[ram_a_o] <= ram_dout_o;
    ram_din_i <= mem[ram_a_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] byte_addr(input logic [31:0] a, input int k);
    return {a[16:2], 2'(k)};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[byte_addr(a, 3)], ref_mem[byte_addr(a, 2)],
            ref_mem[byte_addr(a, 1)], ref_mem[byte_addr(a, 0)]};
  endfunction

  function automatic logic [3:0] eff_sel(input logic [3:0] sel);
`ifdef MEMCTRL_BYTE_SKIP_EN
    return sel;
`else
    return 4'hF;
`endif
  endfunction

  // One transaction; the RAM-side byte sequence expected comes from the spec's rules.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input int exp_lat, input logic [31:0] exp_rd,
                        input string tag);
    logic [16:0] ea[$];
    logic [7:0]  ed[$];
    logic [16:0] oa[$];
    logic [7:0]  od[$];
    logic [3:0]  en;
    int lat;
    en  = we ? eff_sel(sel) : 4'hF;
    lat = -1;
    if (we)
      for (int k = 0; k < 4; k++)
        if (en[k]) begin
          ea.push_back(byte_addr(addr, k));
          ed.push_back(8'(data >> (8 * k)));
          ref_mem[byte_addr(addr, k)] = 8'(data >> (8 * k));
        end
    cache_ce_i = 1'b1; cache_we_i = we; cache_addr_i = addr;
    cache_data_i = data; cache_sel_i = sel;
    step();
    cache_ce_i = 1'b0; cache_addr_i = $urandom; cache_data_i = $urandom;
    for (int c = 0; c < 12; c++) begin
      if (ram_wr_o) begin oa.push_back(ram_a_o); od.push_back(ram_dout_o); end
      if (!we && c < 4) begin
        check({tag, " rd_addr"}, 32'(ram_a_o), 32'(byte_addr(addr, c)));
        check({tag, " rd_nowr"}, 32'(ram_wr_o), 32'd0);
      end
      if (cache_ready_o) begin lat = c; break; end
      step();
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " nwrites"}, 32'(oa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < oa.size(); i++) begin
      check({tag, " wr_addr"}, 32'(oa[i]), 32'(ea[i]));
      check({tag, " wr_data"}, 32'(od[i]), 32'(ed[i]));
    end
    if (!we) check({tag, " rdata"}, cache_data_o, exp_rd);
    step();
    check({tag, " single_pulse"}, 32'(cache_ready_o), 32'd0);
    if (!we) check({tag, " rdata_hold"}, cache_data_o, exp_rd);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [31:0] last_rd, a, d;
    logic [3:0]  s;
    logic        w;
    int          pulses, rdy_at;

    vecs[0] = '{1'b1, 32'h0000_0104, 32'hA1B2_C3D4, 4'hF, 4, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'h4433_2211, 4'hF, 4, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         4'hF, 5, 32'h4433_2211};
    vecs[3] = '{1'b0, 32'hFFFE_0201, 32'h0,         4'h0, 5, 32'h4433_2211};
    vecs[4] = '{1'b1, 32'h0001_FFFF, 32'hDEAD_BEEF, 4'hF, 4, 32'h0};
    vecs[5] = '{1'b0, 32'h0001_FFFC, 32'h0,         4'hF, 5, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 32'h0000_0104, 32'h0,         4'hF, 5, 32'hA1B2_C3D4};

    // Reset held with a live request
    rst = 1'b1; cache_ce_i = 1'b1; cache_we_i = 1'b1; cache_addr_i = 32'h104;
    cache_data_i = 32'hA1B2C3D4; cache_sel_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst ready", 32'(cache_ready_o), 32'd0);
      check("rst wr",    32'(ram_wr_o),      32'd0);
      check("rst addr",  32'(ram_a_o),       32'd0);
      check("rst dout",  32'(ram_dout_o),    32'd0);
      check("rst rdata", cache_data_o,       32'd0);
    end
    cache_ce_i = 1'b0;
    rst = 1'b0;
    step();

    foreach (vecs[i])
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
             vecs[i].lat, vecs[i].rd, $sformatf("vec%0d", i));

    for (int i = 0; i < 3; i++) begin
      step();
      check("idle rdata_hold", cache_data_o, 32'hA1B2_C3D4);
    end

    // Back-to-back: request kept high, changed on seeing ready
    cache_ce_i = 1'b1; cache_we_i = 1'b0; cache_addr_i = 32'h200; cache_sel_i = 4'hF;
    step();
    rdy_at = -1;
    for (int c = 0; c < 12; c++) begin
      if (cache_ready_o) begin rdy_at = c; break; end
      step();
    end
    check("b2b rd latency", 32'(rdy_at), 32'd5);
    check("b2b rdata", cache_data_o, 32'h4433_2211);
    cache_we_i = 1'b1; cache_addr_i = 32'h400; cache_data_i = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) ref_mem[17'h400 + 17'(k)] = 8'(32'h0BAD_F00D >> (8 * k));
    step();
    check("b2b idle ready", 32'(cache_ready_o), 32'd0);
    check("b2b idle wr",    32'(ram_wr_o),      32'd0);
    check("b2b idle addr",  32'(ram_a_o),       32'd0);
    step();
    check("b2b wr0 wr",   32'(ram_wr_o),   32'd1);
    check("b2b wr0 addr", 32'(ram_a_o),    32'h400);
    check("b2b wr0 dout", 32'(ram_dout_o), 32'h0D);
    pulses = 0; rdy_at = -1;
    for (int c = 1; c < 9; c++) begin
      step();
      if (cache_ready_o) begin pulses++; rdy_at = c; cache_ce_i = 1'b0; end
    end
    check("b2b wr pulses",  32'(pulses), 32'd1);
    check("b2b wr latency", 32'(rdy_at), 32'd4);
    check("b2b wr mem", {mem[17'h403], mem[17'h402], mem[17'h401], mem[17'h400]}, 32'h0BAD_F00D);

    // Reset lands on the edge that would advance the write from byte 1 to byte 2
    cache_ce_i = 1'b1; cache_we_i = 1'b1; cache_addr_i = 32'h104; cache_data_i = 32'h5566_7788;
    step();
    cache_ce_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid wr",    32'(ram_wr_o),   32'd0);
    check("rstmid rdata", cache_data_o,    32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (cache_ready_o) pulses++;
      if (ram_wr_o) pulses++;
      step();
    end
    check("rstmid no_activity", 32'(pulses), 32'd0);
    check("rstmid mem", {mem[17'h107], mem[17'h106], mem[17'h105], mem[17'h104]}, 32'hA1B2_7788);
    ref_mem[17'h104] = 8'h88; ref_mem[17'h105] = 8'h77;

    // Byte-enable handling
    do_txn(1'b1, 32'h300, 32'hFFFF_FFFF, 4'hF, 4, 32'h0, "sel_pre");
`ifdef MEMCTRL_BYTE_SKIP_EN
    do_txn(1'b1, 32'h300, 32'hA1B2_C3D4, 4'b0101, 2, 32'h0, "sel0101");
    do_txn(1'b1, 32'h300, 32'h1234_5678, 4'b0000, 0, 32'h0, "sel0000");
    do_txn(1'b0, 32'h300, 32'h0, 4'b0000, 5, 32'hFFB2_FFD4, "sel_rd");
`else
    do_txn(1'b1, 32'h300, 32'hA1B2_C3D4, 4'b0101, 4, 32'h0, "sel0101");
    do_txn(1'b1, 32'h300, 32'h1234_5678, 4'b0000, 4, 32'h0, "sel0000");
    do_txn(1'b0, 32'h300, 32'h0, 4'b0000, 5, 32'h1234_5678, "sel_rd");
`endif

    // Random traffic over a pool of eight pre-written words
    for (int i = 0; i < 8; i++)
      do_txn(1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF, 4, 32'h0, "rnd_init");
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {15'($urandom), 17'h1000 + 17'(4 * $urandom_range(0, 7)) + 17'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom);
      last_rd = ref_word(a);
      if (w) do_txn(1'b1, a, d, s, $countones(eff_sel(s)), 32'h0, "rnd_wr");
      else   do_txn(1'b0, a, d, s, 5, last_rd, "rnd_rd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly downstream of the data cache.
- Turns the cache's 32-bit word requests (fills and write-backs) into sequences of 8-bit accesses on the byte-wide RAM port.
- Returns a one-cycle completion pulse (cache_ready_o) and, for reads, the assembled word to the cache.
- Little-endian: byte k of a word sits at address base+k.

Parameters:
ADDR_WIDTH, 17, width of the RAM byte address; the upper bits of cache_addr_i are dropped.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cache_ce_i  input  1  request valid; sampled only in IDLE
cache_we_i  input  1  1 = write word, 0 = read word
cache_addr_i  input  32  word address; [1:0] ignored (forced 0)
cache_sel_i  input  4  byte enables; used only with MEMCTRL_BYTE_SKIP_EN
cache_data_i  input  32  write data
cache_data_o  output  32  assembled read word; holds until the next read completes
cache_ready_o  output  1  one-cycle completion pulse
ram_a_o  output  ADDR_WIDTH  RAM byte address
ram_wr_o  output  1  RAM byte write strobe
ram_dout_o  output  8  RAM write byte
ram_din_i  input  8  RAM read byte; valid the cycle after its address is driven (1-cycle latency)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: cache_data_o=0, cache_ready_o=0, ram_a_o=0, ram_wr_o=0, ram_dout_o=0; FSM to IDLE; byte counter=0.
- FSM states: IDLE, XFER, RDWAIT, DONE.
- IDLE:
  - If cache_ce_i=1 at edge E0: latch base={addr[ADDR_WIDTH-1:2],2'b00}, we and data; go to XFER with cnt=0.
  - Otherwise stay. Outputs ram_a_o=0, ram_wr_o=0.
- XFER:
  - Drives ram_a_o=base+cnt.
  - Write: ram_wr_o=1, ram_dout_o=data[8cnt+7:8cnt].
  - Read: ram_wr_o=0.
  - cnt increments each edge.
  - After cnt=3: write goes to DONE; read goes to RDWAIT.
- Read capture: at each edge from E2 to E5, the byte on ram_din_i is stored into lane cnt-1 (lane 3 at the RDWAIT edge). Shift/capture register is internal.
- RDWAIT: ram_wr_o=0, ram_a_o=0. At the next edge, load cache_data_o with the full assembled word and go to DONE.
- DONE: cache_ready_o=1 for exactly one cycle; ram_wr_o=0; next edge goes to IDLE.
- Latency, measured from the accept edge E0:
  - Write: four bytes driven in the cycles after E0..E3; cache_ready_o high in the cycle after E4.
  - Read: cache_ready_o high in the cycle after E5, and cache_data_o is valid in that same cycle.
- IDLE is held at least one cycle after DONE, so a cache_ce_i still high with the same request in the DONE cycle is not re-accepted until the IDLE cycle. The cache must drop or change its request on seeing cache_ready_o.
- Request inputs are ignored outside IDLE. cache_ce_i dropping mid-transfer does not abort it; a started write always completes all bytes.
- Address arithmetic: base+cnt never carries out of bit 1. Wrap-around at the top of RAM stays within the same aligned word.
- Reset mid-transfer: at the reset edge ram_wr_o goes to 0 and the FSM goes to IDLE. No cache_ready_o pulse is issued and cache_data_o is cleared to 0. The partial write left in RAM is not undone.
- cache_sel_i is ignored (full-word access) unless the feature below is enabled. Reads always fetch all four bytes.

Optional Feature:
MEMCTRL_BYTE_SKIP_EN
- Defined:
  - Writes visit only byte slots with cache_sel_i[k]=1, in ascending k; disabled slots take no cycle.
  - For a write with N enabled bytes, cache_ready_o is high in the cycle after edge E(N).
  - sel=0000 goes straight from IDLE to DONE, so cache_ready_o is high in the cycle after E0 and there is no RAM write.
  - Reads are unaffected.
- Undefined: every write is four bytes regardless of sel.

Test Plan:
- Reset: hold rst 3 cycles with cache_ce_i=1 -> all outputs 0, no ram_wr_o, FSM in IDLE.
- Write: addr=0x00000104, data=0xA1B2C3D4, we=1 -> ram_a_o/ram_dout_o sequence is 0x104/D4, 0x105/C3, 0x106/B2, 0x107/A1 with ram_wr_o=1 for those 4 cycles; cache_ready_o pulses once, in the cycle after E4.
- Read: RAM bytes 0x200..0x203 = 11,22,33,44 -> ram_a_o 0x200..0x203 with ram_wr_o=0; cache_ready_o in the cycle after E5 with cache_data_o=0x44332211; cache_data_o holds that value through later idle cycles.
- Back-to-back: cache_ce_i held high across a read of 0x200 then, after cache_ready_o, switched to a write -> exactly one IDLE cycle between the transfers, and each transfer gets exactly one pulse.
- Reset mid-write at cnt=2 -> ram_wr_o low from the next cycle, no cache_ready_o pulse, bytes 0x106/0x107 untouched.
- MEMCTRL_BYTE_SKIP_EN, write with sel=0101, data=0xA1B2C3D4 at 0x300 -> only 0x300/D4 and 0x302/B2 written; cache_ready_o in the cycle after E2. sel=0000 -> no write; cache_ready_o in the cycle after E0.
